// File: rtl/leb128_stream_dec.sv
// leb128_stream_dec
//   Byte-serial LEB128 decoder. It accepts one encoded byte per cycle and
//   accumulates a W-bit value. When a terminating byte arrives it registers
//   the value, the number of bytes consumed and an error flag.
//   SIGNED=0 decodes ULEB128. SIGNED=1 decodes SLEB128 and sign-extends.
//
//   State table
//     state    | meaning
//     ST_ACC   | accumulating payload groups of the current value
//     ST_DRAIN | value exceeded MAXB bytes; discarding until a terminator
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    encoded byte (bit7 = continuation, bits6:0 = payload)
//   in_valid   in_data valid
//   in_ready   decoder accepts a byte this cycle
//   out_data   decoded value, truncated to W bits
//   out_len    bytes consumed for this value, saturating at 15
//   out_err    value malformed (overflow or overlong)
//   out_valid  out_data/out_len/out_err valid
//   out_ready  consumer accepts the result
module leb128_stream_dec #(
  parameter int W      = 32,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_len,
  output logic         out_err,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int MAXB = (W + 6) / 7;
  // Number of payload bits of the final legal byte that still land in the value.
  localparam int LAST_USED = W - 7 * (MAXB - 1);
  // Payload bits of the final legal byte that fall beyond bit W-1.
  localparam logic [6:0] UNUSED_MASK = 7'(8'hFF << LAST_USED);

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [3:0]     out_len_q, out_len_d;
  logic           out_err_q, out_err_d;
  logic           out_valid_q, out_valid_d;

  logic [6:0]     payload;
  logic           last_byte;
  logic           accept;
  logic           at_last_idx;
  logic [W-1:0]   shifted;
  logic [W-1:0]   acc_next;
  logic [W-1:0]   sext_mask;
  logic           sext_fill;
  logic           top_ok;
  logic [3:0]     cnt_sat;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign payload   = in_data[6:0];
  assign last_byte = !in_data[7];

  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

  // Datapath helpers for the byte currently at index cnt_q.
  always_comb begin
    at_last_idx = (cnt_q == 4'(MAXB - 1));
    cnt_sat     = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
    // Shifting a W-wide copy drops payload bits above W-1 (truncation).
    shifted     = W'(payload) << (7 * cnt_q);
    acc_next    = acc_q | shifted;
    // Fill from bit 7*(k+1) upward; only used when k < MAXB-1, so the
    // shift is always below W.
    sext_mask   = {W{1'b1}} << (7 * (cnt_q + 4'd1));
    sext_fill   = (SIGNED != 0) && !at_last_idx && payload[6];
    // Overflow check on the final legal byte: unused bits must be zero
    // (unsigned) or copies of the top used bit (signed).
    if (SIGNED != 0) begin
      top_ok = (payload & UNUSED_MASK) ==
               (payload[LAST_USED-1] ? UNUSED_MASK : 7'h00);
    end else begin
      top_ok = (payload & UNUSED_MASK) == 7'h00;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_err_d   = out_err_q;

    // An accepted byte implies the output register is free or being
    // consumed this cycle, so a new result may load unconditionally.
    if (accept) begin
      case (state_q)
        ST_ACC: begin
          acc_d = acc_next;
          cnt_d = cnt_q + 4'd1;
          if (last_byte) begin
            out_valid_d = 1'b1;
            out_data_d  = sext_fill ? (acc_next | sext_mask) : acc_next;
            out_len_d   = cnt_q + 4'd1;
            out_err_d   = at_last_idx && !top_ok;
            cnt_d       = 4'd0;
            acc_d       = '0;
          end else if (at_last_idx) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cnt_d = cnt_sat;
          if (last_byte) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_len_d   = cnt_sat;
            out_err_d   = 1'b1;
            cnt_d       = 4'd0;
            acc_d       = '0;
            state_d     = ST_ACC;
          end
        end
        default: begin
          state_d = ST_ACC;
          cnt_d   = 4'd0;
          acc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      cnt_q       <= 4'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_len_q   <= 4'd0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_leb128_stream_dec.sv
module tb_leb128_stream_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_u, in_ready_s;
  logic [31:0] out_data_u, out_data_s;
  logic [3:0]  out_len_u, out_len_s;
  logic        out_err_u, out_err_s;
  logic        out_valid_u, out_valid_s;

  int checks   = 0;
  int failures = 0;
  int hs       = 0;
  int hs0;

  always #5 clk = ~clk;

  leb128_stream_dec #(.W(32), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_u), .out_data(out_data_u), .out_len(out_len_u),
    .out_err(out_err_u), .out_valid(out_valid_u), .out_ready(out_ready)
  );

  leb128_stream_dec #(.W(32), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .out_data(out_data_s), .out_len(out_len_s),
    .out_err(out_err_s), .out_valid(out_valid_s), .out_ready(out_ready)
  );

  // Output handshakes seen on the unsigned instance.
  always @(posedge clk) begin
    if (rst_n && out_valid_u && out_ready) hs <= hs + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte and wait (bounded) until it is accepted.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ok = in_ready_u;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted byte=%0h", b);
    end
  endtask

  task automatic exp_u(input string tag, input logic [31:0] d, input logic [3:0] l, input logic e);
    chk({tag, "_u_valid"}, 64'(out_valid_u), 64'(1'b1));
    chk({tag, "_u_data"},  64'(out_data_u),  64'(d));
    chk({tag, "_u_len"},   64'(out_len_u),   64'(l));
    chk({tag, "_u_err"},   64'(out_err_u),   64'(e));
  endtask

  task automatic exp_s(input string tag, input logic [31:0] d, input logic [3:0] l, input logic e);
    chk({tag, "_s_valid"}, 64'(out_valid_s), 64'(1'b1));
    chk({tag, "_s_data"},  64'(out_data_s),  64'(d));
    chk({tag, "_s_len"},   64'(out_len_s),   64'(l));
    chk({tag, "_s_err"},   64'(out_err_s),   64'(e));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_valid", 64'(out_valid_u), 64'(1'b0));
    chk("rst_data",  64'(out_data_u),  64'(32'h0));
    chk("rst_len",   64'(out_len_u),   64'(4'h0));
    chk("rst_err",   64'(out_err_u),   64'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready_u), 64'(1'b1));

    // One-byte values on consecutive cycles.
    send(8'h00);
    exp_u("zero", 32'd0, 4'd1, 1'b0);
    send(8'h2A);
    exp_u("v42", 32'd42, 4'd1, 1'b0);

    // Three-byte value with an input gap mid-value.
    send(8'hE5);
    send(8'h8E);
    repeat (3) @(posedge clk);
    #1;
    chk("gap_no_out", 64'(out_valid_u), 64'(1'b0));
    send(8'h26);
    exp_u("v624485", 32'd624485, 4'd3, 1'b0);
    exp_s("v624485", 32'd624485, 4'd3, 1'b0);

    // Max unsigned value: legal unsigned, overflow for signed.
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF); send(8'h0F);
    exp_u("max", 32'hFFFF_FFFF, 4'd5, 1'b0);
    exp_s("max", 32'hFFFF_FFFF, 4'd5, 1'b1);

    // Unsigned overflow.
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF); send(8'h1F);
    exp_u("ovf", 32'hFFFF_FFFF, 4'd5, 1'b1);

    // Overlong, then a clean value.
    for (int i = 0; i < 5; i++) send(8'h80);
    chk("drain_no_out", 64'(out_valid_u), 64'(1'b0));
    send(8'h00);
    exp_u("overlong", 32'd0, 4'd6, 1'b1);
    exp_s("overlong", 32'd0, 4'd6, 1'b1);
    send(8'h05);
    exp_u("after_ol", 32'd5, 4'd1, 1'b0);

    // Signed values.
    send(8'h7F);
    exp_s("m1", 32'hFFFF_FFFF, 4'd1, 1'b0);
    exp_u("m1", 32'h0000_007F, 4'd1, 1'b0);
    send(8'hC0); send(8'hBB); send(8'h78);
    exp_s("m123456", 32'hFFFE_1DC0, 4'd3, 1'b0);
    exp_u("m123456", 32'h001E_1DC0, 4'd3, 1'b0);

    // Backpressure.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h03);
    exp_u("bp_first", 32'd3, 4'd1, 1'b0);
    hs0      = hs;
    in_data  = 8'h04;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 64'(in_ready_u), 64'(1'b0));
      chk("bp_valid",    64'(out_valid_u), 64'(1'b1));
      chk("bp_data",     64'(out_data_u), 64'(32'd3));
      @(posedge clk);
      #1;
    end
    chk("bp_no_hs", 64'(hs), 64'(hs0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_one_hs", 64'(hs), 64'(hs0 + 1));
    exp_u("bp_next", 32'd4, 4'd1, 1'b0);

    // Reset mid-value.
    send(8'hE5);
    send(8'h8E);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid0", 64'(out_valid_u), 64'(1'b0));
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_valid1", 64'(out_valid_u), 64'(1'b0));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    send(8'h01);
    exp_u("rstmid", 32'd1, 4'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
